// File: rtl/wb_conmax_pri_arb.sv
// Slave-side priority/round-robin arbiter for one shared slave port, with a
// bus-hold watchdog that revokes and blocks a master holding the slave too long.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | no grant outstanding; gnt keeps its last value, gnt_vld=0
//   BUSY  | gnt owns the slave; watchdog counts down while req[gnt] stays high
module wb_conmax_pri_arb #(
  parameter int              nm        = 8,
  parameter int              to_w      = 8,
  parameter logic [to_w-1:0] to_cycles = 8'd255
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [nm-1:0]          req,
  input  logic [2*nm-1:0]        pri_conf,
  output logic [$clog2(nm)-1:0]  gnt,
  output logic                   gnt_vld,
  output logic                   to_err,
  output logic [nm-1:0]          blk
);

  localparam int iw = $clog2(nm);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state_q, state_d;
  logic [iw-1:0]     gnt_q, gnt_d;
  logic              gnt_vld_q, gnt_vld_d;
  logic              to_err_q, to_err_d;
  logic [nm-1:0]     blk_q, blk_d;
  logic [iw-1:0]     last_q, last_d;
  logic [to_w-1:0]   cnt_q, cnt_d;

  logic [nm-1:0]     ereq;
  logic [nm-1:0]     gnt_oh;
  logic [nm-1:0]     sel_in;
  logic [nm-1:0]     cand;
  logic [1:0]        maxp;
  logic [iw-1:0]     win;
  logic [iw-1:0]     idx;
  logic              found;
  logic              wd_en;
  logic              held;
  logic              expire;
  logic [to_w-1:0]   cnt_load;

  assign ereq     = req & ~blk_q;
  assign gnt_oh   = {{(nm-1){1'b0}}, 1'b1} << gnt_q;
  assign wd_en    = (to_cycles != '0);
  // Watchdog is a down-counter: loaded with to_cycles-1 on grant, expires at zero.
  assign cnt_load = wd_en ? (to_cycles - 1'b1) : '0;
  assign held     = req[gnt_q];
  assign expire   = (state_q == BUSY) && held && wd_en && (cnt_q == '0);
  assign sel_in   = expire ? (ereq & ~gnt_oh) : ereq;

  // Highest priority among requesters, then circular scan from last+1.
  always_comb begin
    maxp  = 2'd0;
    cand  = '0;
    win   = last_q;
    idx   = last_q;
    found = 1'b0;
    for (int i = 0; i < nm; i++) begin
      if (sel_in[i] && (pri_conf[2*i +: 2] > maxp)) maxp = pri_conf[2*i +: 2];
    end
    for (int i = 0; i < nm; i++) begin
      cand[i] = sel_in[i] && (pri_conf[2*i +: 2] == maxp);
    end
    for (int k = 1; k <= nm; k++) begin
      idx = last_q + iw'(k);
      if (!found && cand[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_vld_d = gnt_vld_q;
    to_err_d  = 1'b0;
    blk_d     = blk_q & req;
    last_d    = last_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (|sel_in) begin
          gnt_d     = win;
          last_d    = win;
          gnt_vld_d = 1'b1;
          cnt_d     = cnt_load;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        if (held && !expire) begin
          if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        end else begin
          if (expire) begin
            to_err_d      = 1'b1;
            blk_d[gnt_q]  = 1'b1;
          end
          if (|sel_in) begin
            gnt_d     = win;
            last_d    = win;
            gnt_vld_d = 1'b1;
            cnt_d     = cnt_load;
          end else begin
            gnt_vld_d = 1'b0;
            state_d   = IDLE;
          end
        end
      end
      default: begin
        gnt_vld_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      gnt_vld_q <= 1'b0;
      to_err_q  <= 1'b0;
      blk_q     <= '0;
      last_q    <= iw'(nm - 1);
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gnt_vld_q <= gnt_vld_d;
      to_err_q  <= to_err_d;
      blk_q     <= blk_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_vld = gnt_vld_q;
  assign to_err  = to_err_q;
  assign blk     = blk_q;

endmodule

// File: tb/tb_wb_conmax_pri_arb.sv
// Directed bench for wb_conmax_pri_arb; watchdog set to 8 cycles so expiry is reachable.
module tb_wb_conmax_pri_arb;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [7:0]  req = 8'h00;
  logic [15:0] pri_conf = 16'h0000;
  logic [2:0]  gnt;
  logic        gnt_vld;
  logic        to_err;
  logic [7:0]  blk;

  int checks = 0;
  int passed = 0;

  wb_conmax_pri_arb #(.nm(8), .to_w(8), .to_cycles(8'd8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req(req), .pri_conf(pri_conf),
    .gnt(gnt), .gnt_vld(gnt_vld), .to_err(to_err), .blk(blk)
  );

  always #5 clk_i = ~clk_i;

  task automatic do_reset();
    req   = 8'h00;
    rst_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    @(negedge clk_i);
    checks++; if (gnt !== 3'd0) $display("FAIL rst_gnt got=%0d exp=0", gnt); else passed++;
    checks++; if (gnt_vld !== 1'b0) $display("FAIL rst_vld got=%b exp=0", gnt_vld); else passed++;
    checks++; if (to_err !== 1'b0) $display("FAIL rst_to_err got=%b exp=0", to_err); else passed++;
    checks++; if (blk !== 8'h00) $display("FAIL rst_blk got=%h exp=00", blk); else passed++;
    rst_i = 1'b0;
    pri_conf = 16'h0000;
    req = 8'h01;
    @(negedge clk_i);
    checks++; if (gnt !== 3'd0) $display("FAIL single_gnt got=%0d exp=0", gnt); else passed++;
    checks++; if (gnt_vld !== 1'b1) $display("FAIL single_vld got=%b exp=1", gnt_vld); else passed++;
    req = 8'h00;
    @(negedge clk_i);
    checks++; if (gnt_vld !== 1'b0) $display("FAIL drop_vld got=%b exp=0", gnt_vld); else passed++;
    checks++; if (gnt !== 3'd0) $display("FAIL drop_gnt_hold got=%0d exp=0", gnt); else passed++;
  endtask

  task automatic test_round_robin();
    int exp_g[6] = '{0, 1, 3, 0, 1, 3};
    do_reset();
    pri_conf = 16'h0000;
    req = 8'h0B;
    @(negedge clk_i);
    for (int g = 0; g < 6; g++) begin
      checks++; if (gnt !== 3'(exp_g[g])) $display("FAIL rr_gnt[%0d] got=%0d exp=%0d", g, gnt, exp_g[g]); else passed++;
      checks++; if (gnt_vld !== 1'b1) $display("FAIL rr_vld[%0d] got=%b exp=1", g, gnt_vld); else passed++;
      if (g > 0) req[exp_g[g-1]] = 1'b1;
      repeat (3) @(negedge clk_i);
      req[exp_g[g]] = 1'b0;
      @(negedge clk_i);
    end
    req = 8'h00;
    repeat (2) @(negedge clk_i);
  endtask

  task automatic test_priority();
    pri_conf = 16'h00C0;
    req = 8'h0F;
    @(negedge clk_i);
    checks++; if (gnt !== 3'd3) $display("FAIL pri_first got=%0d exp=3", gnt); else passed++;
    pri_conf = 16'h0003;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      checks++; if (gnt !== 3'd3) $display("FAIL pri_hold[%0d] got=%0d exp=3", i, gnt); else passed++;
    end
    req = 8'h07;
    @(negedge clk_i);
    checks++; if (gnt !== 3'd0) $display("FAIL pri_after got=%0d exp=0", gnt); else passed++;
    checks++; if (gnt_vld !== 1'b1) $display("FAIL pri_after_vld got=%b exp=1", gnt_vld); else passed++;
    req = 8'h00;
    pri_conf = 16'h0000;
    repeat (2) @(negedge clk_i);
  endtask

  task automatic test_watchdog();
    do_reset();
    req = 8'h06;
    @(negedge clk_i);
    for (int i = 0; i < 8; i++) begin
      checks++; if (gnt !== 3'd1 || to_err !== 1'b0) $display("FAIL wd_hold[%0d] gnt=%0d to_err=%b exp gnt=1 to_err=0", i, gnt, to_err); else passed++;
      @(negedge clk_i);
    end
    checks++; if (to_err !== 1'b1) $display("FAIL wd_to_err got=%b exp=1", to_err); else passed++;
    checks++; if (gnt !== 3'd2) $display("FAIL wd_gnt got=%0d exp=2", gnt); else passed++;
    checks++; if (blk !== 8'h02) $display("FAIL wd_blk got=%h exp=02", blk); else passed++;
    checks++; if (gnt_vld !== 1'b1) $display("FAIL wd_vld got=%b exp=1", gnt_vld); else passed++;
    @(negedge clk_i);
    checks++; if (to_err !== 1'b0) $display("FAIL wd_pulse got=%b exp=0", to_err); else passed++;
    checks++; if (blk !== 8'h02) $display("FAIL wd_blk_keep got=%h exp=02", blk); else passed++;
    req = 8'h04;
    @(negedge clk_i);
    checks++; if (blk !== 8'h00) $display("FAIL wd_blk_clr got=%h exp=00", blk); else passed++;
    req = 8'h06;
    @(negedge clk_i);
    checks++; if (gnt !== 3'd2) $display("FAIL wd_keep_gnt got=%0d exp=2", gnt); else passed++;
    req = 8'h00;
    @(negedge clk_i);
    checks++; if (gnt_vld !== 1'b0) $display("FAIL wd_idle got=%b exp=0", gnt_vld); else passed++;
  endtask

  task automatic test_release_on_expiry();
    do_reset();
    req = 8'h06;
    @(negedge clk_i);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) req = 8'h04;
      @(negedge clk_i);
    end
    checks++; if (to_err !== 1'b0) $display("FAIL coin_to_err got=%b exp=0", to_err); else passed++;
    checks++; if (blk !== 8'h00) $display("FAIL coin_blk got=%h exp=00", blk); else passed++;
    checks++; if (gnt !== 3'd2 || gnt_vld !== 1'b1) $display("FAIL coin_gnt gnt=%0d vld=%b exp gnt=2 vld=1", gnt, gnt_vld); else passed++;
    @(negedge clk_i);
    checks++; if (to_err !== 1'b0) $display("FAIL coin_to_err2 got=%b exp=0", to_err); else passed++;
    req = 8'h00;
    repeat (2) @(negedge clk_i);
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 8'h22;
    repeat (9) @(negedge clk_i);
    checks++; if (gnt !== 3'd5 || gnt_vld !== 1'b1) $display("FAIL ar_pre gnt=%0d vld=%b exp gnt=5 vld=1", gnt, gnt_vld); else passed++;
    checks++; if (blk !== 8'h02 || to_err !== 1'b1) $display("FAIL ar_pre_wd blk=%h to_err=%b exp blk=02 to_err=1", blk, to_err); else passed++;
    #2 rst_i = 1'b1;
    #1;
    checks++; if (gnt !== 3'd0) $display("FAIL ar_gnt got=%0d exp=0", gnt); else passed++;
    checks++; if (gnt_vld !== 1'b0) $display("FAIL ar_vld got=%b exp=0", gnt_vld); else passed++;
    checks++; if (blk !== 8'h00) $display("FAIL ar_blk got=%h exp=00", blk); else passed++;
    checks++; if (to_err !== 1'b0) $display("FAIL ar_to_err got=%b exp=0", to_err); else passed++;
    @(negedge clk_i);
    pri_conf = 16'h0000;
    req = 8'hFF;
    rst_i = 1'b0;
    @(negedge clk_i);
    checks++; if (gnt !== 3'd0 || gnt_vld !== 1'b1) $display("FAIL ar_ptr gnt=%0d vld=%b exp gnt=0 vld=1", gnt, gnt_vld); else passed++;
    req = 8'h00;
    repeat (2) @(negedge clk_i);
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_priority();
    test_watchdog();
    test_release_on_expiry();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/wb_conmax_pri_arb.md
Name: wb_conmax_pri_arb

Overview:
- Slave-side arbiter for the connection matrix. It shares one slave port between 8 masters.
- Arbitration is by 2-bit per-master priority taken from one 16-bit configuration register output (confN) of the register file. Round-robin applies among masters of equal priority.
- Includes a bus-hold watchdog. It revokes the grant from a master that holds the slave too long and flags an error.
- The grant index drives the slave-port data/control muxes in the matrix.

Parameters:
- nm, 8, number of masters (fixed at 8 for this release; pri_conf width is 2*nm).
- to_w, 8, width of the watchdog counter.
- to_cycles, 8'd255, max consecutive granted cycles before forced release; 0 disables the watchdog.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous active-high reset.
- req  in  8  per-master request (master cyc_o & slave decode hit).
- pri_conf  in  16  priority config; bits [2i+1:2i] = priority of master i, 3 highest.
- gnt  out  3  index of granted master.
- gnt_vld  out  1  grant valid; slave cyc is gated by this.
- to_err  out  1  one-cycle pulse on watchdog revoke.
- blk  out  8  masters currently blocked by the watchdog (debug/status).

Behaviour:
- Reset (async, rst_i=1):
  - gnt=0, gnt_vld=0, to_err=0, blk=0.
  - Internal last-grant pointer=7.
  - Watchdog count=0, state=IDLE.
- Effective request: ereq = req & ~blk.
- Selection function SEL(ereq):
  - maxp = highest pri_conf field among set ereq bits.
  - Candidates = ereq bits whose priority equals maxp.
  - Winner = first candidate scanning circularly from last+1 (mod 8).
  - pri_conf is sampled combinationally at each arbitration edge only. Changes never preempt a held grant.
- State IDLE:
  - If ereq==0: stay; gnt holds its last value; gnt_vld=0.
  - Else, at the next edge: gnt=SEL(ereq), gnt_vld=1, last=winner, count=0, go BUSY. Latency is 1 cycle from req to gnt_vld.
- State BUSY:
  - req[gnt]=1 and watchdog not expired: hold gnt; count++ (saturating).
  - req[gnt]=0 (master released), next edge:
    - If ereq!=0: gnt=SEL(ereq), gnt_vld stays 1, count=0. This is a zero-bubble handover.
    - If ereq==0: gnt_vld=0, go IDLE.
  - Watchdog expiry: to_cycles!=0, count==to_cycles-1, and req[gnt] still 1. At that edge:
    - to_err=1 for one cycle; blk[gnt]=1.
    - Rearbitrate over ereq excluding gnt, with the same handover rule. If none remain, gnt_vld=0 and go IDLE.
- blk[i] clears on any edge where req[i]=0. The master must drop cyc before it can be regranted.
- Simultaneous release and expiry: release wins; no to_err, no blk set.
- Single requester: it is regranted repeatedly; RR has no effect.
- blk set and cleared for different masters on the same edge are independent.
- Reset asserted mid-transfer: immediate return to reset values; no to_err.
- Count width: to_w bits, saturating; to_cycles must be < 2^to_w.

Test Plan:
1. Reset, pri_conf=16'h0000, req=8'h01 -> next cycle gnt=0, gnt_vld=1. Drop req -> next cycle gnt_vld=0, gnt stays 0.
2. Equal priority RR: pri_conf=0, req=8'h0B held, each master releases after 4 cycles and re-requests 1 cycle later -> grant order 0,1,3,0,1,3 with no idle cycle between grants.
3. Priority: pri_conf=16'h00C0 (master3=3), req=8'h0F -> gnt=3 first. Change pri_conf to 16'h0003 while 3 is held -> gnt stays 3 until req[3] drops, then gnt=0.
4. Watchdog: to_cycles=8, req=8'h06, master1 never releases -> gnt=1 for exactly 8 cycles, then to_err pulses 1 cycle, gnt=2, blk=8'h02. req[1] low one cycle -> blk=0.
5. Release and expiry coincide: req[gnt] drops on the expiry cycle -> to_err=0, blk unchanged, normal handover.
6. rst_i asserted asynchronously while gnt=5, gnt_vld=1 -> gnt=0, gnt_vld=0, blk=0, to_err=0 immediately. After release, req=8'hFF with pri_conf=0 -> gnt=0 (pointer reset to 7).
